// File: rtl/control_unit.sv
// Hardwired control sequencer: fetches through PC/MAR/MDR/IR, decodes
// ir[31:27] and steps through per-class T-states driving datapath strobes.
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        RYin,
  output logic        RZin,
  output logic        RZLOout,
  output logic        RZHIout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        PORTin,
  output logic        PORTout,
  output logic        CONin,
  output logic        R15in,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        BAout,
  output logic        Cout
);

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_UNARY,
    C_BRX, C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT
  } iclass_t;

  state_t      state, state_next;
  iclass_t     iclass;
  logic [4:0]  opcode;
  logic        unused_ir;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];

  // Opcode to instruction-class decode.
  always_comb begin
    iclass = C_NOP;
    case (opcode) inside
      5'd0:            iclass = C_LD;
      5'd1:            iclass = C_LDI;
      5'd2:            iclass = C_ST;
      [5'd3:5'd11]:    iclass = C_ALU;
      [5'd12:5'd14]:   iclass = C_IMM;
      [5'd15:5'd16]:   iclass = C_MULDIV;
      [5'd17:5'd18]:   iclass = C_UNARY;
      5'd19:           iclass = C_BRX;
      5'd20:           iclass = C_JR;
      5'd21:           iclass = C_JAL;
      5'd22:           iclass = C_IN;
      5'd23:           iclass = C_OUT;
      5'd24:           iclass = C_MFHI;
      5'd25:           iclass = C_MFLO;
      5'd27:           iclass = C_HALT;
      default:         iclass = C_NOP;
    endcase
  end

  // State register; clear forces RST immediately.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= ST_RST;
    else        state <= state_next;
  end

  // Next-state and control strobes from state, class and con_ff.
  always_comb begin
    state_next = state;
    run     = 1'b0;
    PCout   = 1'b0; IncPC   = 1'b0; PCin    = 1'b0; MARin   = 1'b0;
    MDRin   = 1'b0; MDRout  = 1'b0; Read    = 1'b0; Write   = 1'b0;
    IRin    = 1'b0; RYin    = 1'b0; RZin    = 1'b0; RZLOout = 1'b0;
    RZHIout = 1'b0; HIin    = 1'b0; LOin    = 1'b0; HIout   = 1'b0;
    LOout   = 1'b0; PORTin  = 1'b0; PORTout = 1'b0; CONin   = 1'b0;
    R15in   = 1'b0; gra     = 1'b0; grb     = 1'b0; grc     = 1'b0;
    rin     = 1'b0; rout    = 1'b0; BAout   = 1'b0; Cout    = 1'b0;

    case (state)
      ST_RST: state_next = ST_T0;

      ST_T0: begin
        run = 1'b1;
        if (stop) begin
          state_next = ST_HALT;
        end else begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
          state_next = ST_T1;
        end
      end

      ST_T1: begin
        run = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_next = ST_T2;
      end

      ST_T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        state_next = ST_T3;
      end

      ST_T3: begin
        run = 1'b1;
        state_next = ST_T4;
        case (iclass)
          C_LD, C_ST, C_LDI: begin grb = 1'b1; BAout = 1'b1; RYin = 1'b1; end
          C_ALU, C_IMM:      begin grb = 1'b1; rout = 1'b1; RYin = 1'b1; end
          C_MULDIV:          begin gra = 1'b1; rout = 1'b1; RYin = 1'b1; end
          C_UNARY:           begin grb = 1'b1; rout = 1'b1; RZin = 1'b1; end
          C_BRX:             begin grb = 1'b1; rout = 1'b1; CONin = 1'b1; end
          C_JAL:             begin PCout = 1'b1; R15in = 1'b1; end
          C_JR: begin
            gra = 1'b1; rout = 1'b1; PCin = 1'b1;
            state_next = ST_T0;
          end
          C_IN: begin
            PORTout = 1'b1; gra = 1'b1; rin = 1'b1;
            state_next = ST_T0;
          end
          C_OUT: begin
            gra = 1'b1; rout = 1'b1; PORTin = 1'b1;
            state_next = ST_T0;
          end
          C_MFHI: begin
            HIout = 1'b1; gra = 1'b1; rin = 1'b1;
            state_next = ST_T0;
          end
          C_MFLO: begin
            LOout = 1'b1; gra = 1'b1; rin = 1'b1;
            state_next = ST_T0;
          end
          C_HALT:  state_next = ST_HALT;
          default: state_next = ST_T0;
        endcase
      end

      ST_T4: begin
        run = 1'b1;
        state_next = ST_T5;
        case (iclass)
          C_LD, C_ST, C_LDI, C_IMM: begin Cout = 1'b1; RZin = 1'b1; end
          C_ALU:    begin grc = 1'b1; rout = 1'b1; RZin = 1'b1; end
          C_MULDIV: begin grb = 1'b1; rout = 1'b1; RZin = 1'b1; end
          C_BRX:    begin PCout = 1'b1; RYin = 1'b1; end
          C_UNARY: begin
            RZLOout = 1'b1; gra = 1'b1; rin = 1'b1;
            state_next = ST_T0;
          end
          C_JAL: begin
            gra = 1'b1; rout = 1'b1; PCin = 1'b1;
            state_next = ST_T0;
          end
          default: state_next = ST_T0;
        endcase
      end

      ST_T5: begin
        run = 1'b1;
        state_next = ST_T6;
        case (iclass)
          C_LD, C_ST: begin RZLOout = 1'b1; MARin = 1'b1; end
          C_MULDIV:   begin RZLOout = 1'b1; LOin = 1'b1; end
          C_BRX:      begin Cout = 1'b1; RZin = 1'b1; end
          C_LDI, C_ALU, C_IMM: begin
            RZLOout = 1'b1; gra = 1'b1; rin = 1'b1;
            state_next = ST_T0;
          end
          default: state_next = ST_T0;
        endcase
      end

      ST_T6: begin
        run = 1'b1;
        state_next = ST_T0;
        case (iclass)
          C_LD: begin
            Read = 1'b1; MDRin = 1'b1;
            state_next = ST_T7;
          end
          C_ST: begin
            gra = 1'b1; rout = 1'b1; MDRin = 1'b1;
            state_next = ST_T7;
          end
          C_MULDIV: begin RZHIout = 1'b1; HIin = 1'b1; end
          C_BRX:    begin RZLOout = 1'b1; PCin = con_ff; end
          default: ;
        endcase
      end

      ST_T7: begin
        run = 1'b1;
        state_next = ST_T0;
        case (iclass)
          C_LD:    begin MDRout = 1'b1; gra = 1'b1; rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end

      ST_HALT: state_next = ST_HALT;

      default: state_next = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against a per-opcode
// step-table model of the expected strobe sequence.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        con_ff = 1'b0;
  logic        stop = 1'b0;
  logic run, PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, Write, IRin;
  logic RYin, RZin, RZLOout, RZHIout, HIin, LOin, HIout, LOout, PORTin;
  logic PORTout, CONin, R15in, gra, grb, grc, rin, rout, BAout, Cout;

  localparam logic [31:0] M_RUN   = 32'h1 << 0;
  localparam logic [31:0] M_PCOUT = 32'h1 << 1;
  localparam logic [31:0] M_INCPC = 32'h1 << 2;
  localparam logic [31:0] M_PCIN  = 32'h1 << 3;
  localparam logic [31:0] M_MARIN = 32'h1 << 4;
  localparam logic [31:0] M_MDRIN = 32'h1 << 5;
  localparam logic [31:0] M_MDROUT= 32'h1 << 6;
  localparam logic [31:0] M_READ  = 32'h1 << 7;
  localparam logic [31:0] M_WRITE = 32'h1 << 8;
  localparam logic [31:0] M_IRIN  = 32'h1 << 9;
  localparam logic [31:0] M_RYIN  = 32'h1 << 10;
  localparam logic [31:0] M_RZIN  = 32'h1 << 11;
  localparam logic [31:0] M_RZLO  = 32'h1 << 12;
  localparam logic [31:0] M_RZHI  = 32'h1 << 13;
  localparam logic [31:0] M_HIIN  = 32'h1 << 14;
  localparam logic [31:0] M_LOIN  = 32'h1 << 15;
  localparam logic [31:0] M_HIOUT = 32'h1 << 16;
  localparam logic [31:0] M_LOOUT = 32'h1 << 17;
  localparam logic [31:0] M_PORTIN= 32'h1 << 18;
  localparam logic [31:0] M_PORTOUT=32'h1 << 19;
  localparam logic [31:0] M_CONIN = 32'h1 << 20;
  localparam logic [31:0] M_R15IN = 32'h1 << 21;
  localparam logic [31:0] M_GRA   = 32'h1 << 22;
  localparam logic [31:0] M_GRB   = 32'h1 << 23;
  localparam logic [31:0] M_GRC   = 32'h1 << 24;
  localparam logic [31:0] M_RIN   = 32'h1 << 25;
  localparam logic [31:0] M_ROUT  = 32'h1 << 26;
  localparam logic [31:0] M_BAOUT = 32'h1 << 27;
  localparam logic [31:0] M_COUT  = 32'h1 << 28;

  logic [31:0] obs;
  logic [9:0]  bus_src;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic        exp_halt;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
    .run(run), .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin),
    .RYin(RYin), .RZin(RZin), .RZLOout(RZLOout), .RZHIout(RZHIout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .PORTin(PORTin), .PORTout(PORTout), .CONin(CONin), .R15in(R15in),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout),
    .BAout(BAout), .Cout(Cout)
  );

  always #5 clock = ~clock;

  assign obs = {3'b000, Cout, BAout, rout, rin, grc, grb, gra, R15in, CONin,
                PORTout, PORTin, LOout, HIout, LOin, HIin, RZHIout, RZLOout,
                RZin, RYin, IRin, Write, Read, MDRout, MDRin, MARin, PCin,
                IncPC, PCout, run};
  assign bus_src = {PCout, MDRout, RZLOout, RZHIout, HIout, LOout, PORTout,
                    rout, BAout, Cout};

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Invariants that hold in every cycle.
  task automatic check_rules(input string tag);
    check_eq({tag, "_rw"}, 32'(Read & Write), 32'h0);
    check_eq({tag, "_bus"}, 32'($countones(bus_src) > 1), 32'h0);
  endtask

  // Expected per-cycle strobe list for one instruction, fetch included.
  task automatic build_seq(input logic [4:0] op, input logic con);
    exp_q.delete();
    exp_halt = 1'b0;
    exp_q.push_back(M_PCOUT | M_MARIN | M_INCPC);
    exp_q.push_back(M_READ | M_MDRIN);
    exp_q.push_back(M_MDROUT | M_IRIN);
    if (op == 5'd0 || op == 5'd2) begin
      exp_q.push_back(M_GRB | M_BAOUT | M_RYIN);
      exp_q.push_back(M_COUT | M_RZIN);
      exp_q.push_back(M_RZLO | M_MARIN);
      if (op == 5'd0) begin
        exp_q.push_back(M_READ | M_MDRIN);
        exp_q.push_back(M_MDROUT | M_GRA | M_RIN);
      end else begin
        exp_q.push_back(M_GRA | M_ROUT | M_MDRIN);
        exp_q.push_back(M_WRITE);
      end
    end else if (op == 5'd1 || (op >= 5'd12 && op <= 5'd14)) begin
      exp_q.push_back(M_GRB | ((op == 5'd1) ? M_BAOUT : M_ROUT) | M_RYIN);
      exp_q.push_back(M_COUT | M_RZIN);
      exp_q.push_back(M_RZLO | M_GRA | M_RIN);
    end else if (op >= 5'd3 && op <= 5'd11) begin
      exp_q.push_back(M_GRB | M_ROUT | M_RYIN);
      exp_q.push_back(M_GRC | M_ROUT | M_RZIN);
      exp_q.push_back(M_RZLO | M_GRA | M_RIN);
    end else if (op == 5'd15 || op == 5'd16) begin
      exp_q.push_back(M_GRA | M_ROUT | M_RYIN);
      exp_q.push_back(M_GRB | M_ROUT | M_RZIN);
      exp_q.push_back(M_RZLO | M_LOIN);
      exp_q.push_back(M_RZHI | M_HIIN);
    end else if (op == 5'd17 || op == 5'd18) begin
      exp_q.push_back(M_GRB | M_ROUT | M_RZIN);
      exp_q.push_back(M_RZLO | M_GRA | M_RIN);
    end else if (op == 5'd19) begin
      exp_q.push_back(M_GRB | M_ROUT | M_CONIN);
      exp_q.push_back(M_PCOUT | M_RYIN);
      exp_q.push_back(M_COUT | M_RZIN);
      exp_q.push_back(M_RZLO | (con ? M_PCIN : 32'h0));
    end else if (op == 5'd20) exp_q.push_back(M_GRA | M_ROUT | M_PCIN);
    else if (op == 5'd21) begin
      exp_q.push_back(M_PCOUT | M_R15IN);
      exp_q.push_back(M_GRA | M_ROUT | M_PCIN);
    end
    else if (op == 5'd22) exp_q.push_back(M_PORTOUT | M_GRA | M_RIN);
    else if (op == 5'd23) exp_q.push_back(M_GRA | M_ROUT | M_PORTIN);
    else if (op == 5'd24) exp_q.push_back(M_HIOUT | M_GRA | M_RIN);
    else if (op == 5'd25) exp_q.push_back(M_LOOUT | M_GRA | M_RIN);
    else begin
      exp_q.push_back(32'h0);
      exp_halt = (op == 5'd27);
    end
    foreach (exp_q[i]) exp_q[i] = exp_q[i] | M_RUN;
  endtask

  // Check that the unit sits in HALT for n cycles whatever stop/ir do.
  task automatic check_halted(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock); #1;
      stop = 1'($urandom);
      ir = $urandom;
      #1;
      check_eq($sformatf("%s_halt%0d", tag, c), obs, 32'h0);
    end
  endtask

  // Run one instruction starting from the edge that enters T0; abort_k >= 0
  // asserts clear right after that step has been checked.
  task automatic run_instr(input logic [4:0] op, input logic con,
                           input string tag, input int abort_k);
    int n;
    build_seq(op, con);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      if (k == 0) begin
        ir = {op, 27'($urandom)};
        con_ff = con;
      end
      stop = (k > 0 && k < n - 1) ? 1'($urandom) : 1'b0;
      #1;
      check_eq($sformatf("%s_s%0d", tag, k), obs, exp_q[k]);
      check_rules(tag);
      if (k == abort_k) begin
        clear = 1'b0;
        #1;
        check_eq({tag, "_abort"}, obs, 32'h0);
        return;
      end
    end
    if (exp_halt) check_halted(tag, 20);
  endtask

  // Hold clear low for a number of edges, then release and check RST.
  task automatic do_reset(input int cycles, input string tag);
    clear = 1'b0;
    stop = 1'b0;
    #1;
    check_eq({tag, "_async"}, obs, 32'h0);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clock); #1;
      check_eq($sformatf("%s_hold%0d", tag, c), obs, 32'h0);
    end
    @(negedge clock);
    clear = 1'b1;
    #1;
    check_eq({tag, "_rst"}, obs, 32'h0);
  endtask

  initial begin
    logic [4:0] op;
    do_reset(3, "reset0");

    run_instr(5'd3,  1'b0, "add", -1);
    run_instr(5'd0,  1'b0, "ld", -1);
    run_instr(5'd2,  1'b0, "st", -1);
    run_instr(5'd19, 1'b1, "brx1", -1);
    run_instr(5'd19, 1'b0, "brx0", -1);
    run_instr(5'd15, 1'b0, "mul", -1);
    run_instr(5'd21, 1'b0, "jal", -1);
    run_instr(5'd28, 1'b0, "ill", -1);

    for (int i = 0; i < 200; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run_instr(op, 1'($urandom), $sformatf("rnd%0d_op%0d", i, op), -1);
    end

    run_instr(5'd27, 1'b0, "haltop", -1);
    do_reset(1, "reset1");

    // stop sampled at T0: no strobes, then HALT.
    @(posedge clock); #1;
    ir = $urandom;
    stop = 1'b1;
    #1;
    check_eq("stop_t0", obs, M_RUN);
    check_halted("stop", 20);
    do_reset(2, "reset2");

    run_instr(5'd3, 1'b0, "add_abort", 4);
    do_reset(1, "reset3");
    run_instr(5'd3, 1'b0, "add_after", -1);
    run_instr(5'd22, 1'b0, "in_after", -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer that drives the bus-based datapath's control inputs. It fetches each instruction through PC/MAR/MDR/IR, then decodes IR[31:27] and steps through per-class T-states, asserting register-select, bus-source, load and memory strobes. It has no datapath storage of its own beyond its state register.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-low reset.
- ir  in  32  IR contents; opcode = ir[31:27].
- con_ff  in  1  branch-condition flag from the datapath CON logic.
- stop  in  1  halt request, sampled at instruction boundary.
- run  out  1  1 while sequencing; 0 in RST and HALT.
- PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, Write, IRin  out  1 each  fetch/memory controls.
- RYin, RZin, RZLOout, RZHIout, HIin, LOin, HIout, LOout, PORTin, PORTout, CONin, R15in  out  1 each.
- gra, grb, grc, rin, rout, BAout, Cout  out  1 each  select/encode-logic controls.

## Operation
- States: RST, T0–T7, HALT. All outputs are 0 unless listed for the current state.
- RST: entered asynchronously while clear=0; next state T0.
- T0: if stop=1, go to HALT with no outputs asserted. Otherwise assert PCout, MARin, IncPC.
- T1: Read, MDRin.
- T2: MDRout, IRin.
- Execution begins at T3. The last listed step returns to T0.
- Opcodes:
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011
  - addi 01100, andi 01101, ori 01110
  - mul 01111, div 10000, neg 10001, not 10010
  - brx 10011, jr 10100, jal 10101
  - in 10110, out 10111, mfhi 11000, mflo 11001
  - nop 11010, halt 11011
  - 11100–11111 are treated as nop.
- R-type (00011–01011):
  - T3 grb,rout,RYin
  - T4 grc,rout,RZin
  - T5 RZLOout,gra,rin
- addi/andi/ori:
  - T3 grb,rout,RYin
  - T4 Cout,RZin
  - T5 RZLOout,gra,rin
- ldi: same as addi/andi/ori, except T3 uses BAout in place of rout.
- ld:
  - T3 grb,BAout,RYin
  - T4 Cout,RZin
  - T5 RZLOout,MARin
  - T6 Read,MDRin
  - T7 MDRout,gra,rin
- st:
  - T3–T5 as ld
  - T6 gra,rout,MDRin (Read=0)
  - T7 Write
- mul/div:
  - T3 gra,rout,RYin
  - T4 grb,rout,RZin
  - T5 RZLOout,LOin
  - T6 RZHIout,HIin
- neg/not:
  - T3 grb,rout,RZin
  - T4 RZLOout,gra,rin
- brx:
  - T3 grb,rout,CONin
  - T4 PCout,RYin
  - T5 Cout,RZin
  - T6 RZLOout, plus PCin only if con_ff=1
- jr: T3 gra,rout,PCin.
- jal:
  - T3 PCout,R15in
  - T4 gra,rout,PCin
- in: T3 PORTout,gra,rin.
- out: T3 gra,rout,PORTin.
- mfhi: T3 HIout,gra,rin.
- mflo: T3 LOout,gra,rin.
- nop/illegal: T3 asserts nothing, then returns to T0.
- halt: T3 asserts nothing, then goes to HALT.
- HALT: all outputs 0. It exits only via clear.
- ir is sampled combinationally from T3 onward. The IR is stable because IRin is asserted only in T2.

## Timing
- State register is reset asynchronously to RST. run=0 and all strobes are 0 immediately on clear=0, independent of clock.
- Outputs are combinational from state and ir. con_ff enters combinationally only in brx T6.
- run=1 in T0–T7.
- Cycles per instruction, fetch included:
  - 4: jr, in, out, mfhi, mflo, nop
  - 5: neg, not, jal
  - 6: R-type, immediate, ldi
  - 7: mul, div, brx
  - 8: ld, st
- Memory read is one cycle: Read in T1 or T6 with MDRin, and data is used the next cycle.
- Read and Write are never high in the same cycle.
- At most one bus-source signal is high per cycle. rout and BAout count as sources.
- stop is sampled only in T0. A stop pulse outside T0 is ignored.
- Reset mid-instruction abandons the instruction. After release, the unit restarts with RST, then T0.

## Test plan
- Reset: hold clear=0 for 3 cycles, release. Required: all outputs 0 and run=0 during reset; RST for 1 cycle; T0 asserts PCout,MARin,IncPC with run=1.
- add (ir=0x18000000 class 00011): T3 grb,rout,RYin; T4 grc,rout,RZin; T5 RZLOout,gra,rin; back to T0 on cycle 7 after RST.
- ld then st: ld shows Read,MDRin in T1 and T6, and MDRout,gra,rin in T7. st shows Write only in T7, with Read=0 there.
- brx with con_ff=1 then con_ff=0: PCin=1 in T6 for the first and 0 for the second; both return to T0 after T6.
- mul: LOin in T5 and HIin in T6. jal: R15in in T3 and PCin in T4.
- halt opcode, and stop=1 at T0: both reach HALT with run=0 and stay there for 20 cycles; clear=0 pulsed in T4 of an add restarts at RST→T0.
